// File: rtl/seg_dyn_scan.sv
`default_nettype none
// ============================================================================
//  Module   : seg_dyn_scan
//  Purpose  : Time-multiplexed scan controller for a six-digit common-anode
//             seven-segment display. Each digit owns a fixed slot of
//             CNT_MAX+1 clocks. The first BLANK_CYC clocks of every slot are
//             blanked to suppress ghosting. New content is double-buffered
//             and swapped in only at a frame boundary.
//  Ports    : sys_clk, sys_rst_n (async, active-low)
//             load, data_in[23:0], dot_in[5:0], lz_en  - content load strobe
//             pending      - captured content waits for next frame boundary
//             frame_start  - one-cycle pulse on first cycle of each frame
//             sel[5:0]     - one-hot digit select, active-high
//             seg[7:0]     - {dp,g,f,e,d,c,b,a}, active-low
//  Revision : 1.0 - initial release
// ============================================================================
module seg_dyn_scan #(
    parameter int CNT_MAX   = 49999,
    parameter int BLANK_CYC = 100
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        load,
    input  logic [23:0] data_in,
    input  logic [5:0]  dot_in,
    input  logic        lz_en,
    output logic        pending,
    output logic        frame_start,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);

    localparam int            CW        = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CW-1:0] C_CNT_MAX = CW'(CNT_MAX);
    localparam logic [CW-1:0] C_BLANK   = CW'(BLANK_CYC);
    localparam logic [2:0]    C_IDX_MAX = 3'd5;

    // Segment lookup, lower seven bits {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] f_hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [23:0]   r_act_data, r_pnd_data;
    logic [5:0]    r_act_dot,  r_pnd_dot;
    logic          r_act_lz,   r_pnd_lz;
    logic          r_pending;
    logic          r_frame_start;
    logic [5:0]    r_sel;
    logic [7:0]    r_seg;

    logic          w_cnt_wrap;
    logic          w_boundary;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_idx_nxt;
    logic [23:0]   w_act_data_nxt;
    logic [5:0]    w_act_dot_nxt;
    logic          w_act_lz_nxt;
    logic [5:0]    w_lz_zero;
    logic [5:0]    w_blank;
    logic [3:0]    w_dig;
    logic          w_dig_dot;
    logic          w_dig_blank;
    logic [7:0]    w_seg_nxt;

    assign w_cnt_wrap = (r_cnt == C_CNT_MAX);
    assign w_boundary = w_cnt_wrap && (r_idx == C_IDX_MAX);
    assign w_cnt_nxt  = w_cnt_wrap ? '0 : r_cnt + 1'b1;
    assign w_idx_nxt  = !w_cnt_wrap          ? r_idx :
                        (r_idx == C_IDX_MAX) ? 3'd0  : r_idx + 3'd1;

    // Active content as it will be after this edge. Outputs are computed from
    // it so that slot 0 of a new frame already shows freshly swapped content.
    always_comb begin
        w_act_data_nxt = r_act_data;
        w_act_dot_nxt  = r_act_dot;
        w_act_lz_nxt   = r_act_lz;
        if (w_boundary) begin
            if (load) begin
                w_act_data_nxt = data_in;
                w_act_dot_nxt  = dot_in;
                w_act_lz_nxt   = lz_en;
            end else if (r_pending) begin
                w_act_data_nxt = r_pnd_data;
                w_act_dot_nxt  = r_pnd_dot;
                w_act_lz_nxt   = r_pnd_lz;
            end
        end
    end

    // w_lz_zero[n]: digit n and every digit above it are zero.
    // Digit 0 is excluded from blanking so a value of zero still shows "0".
    always_comb begin
        w_lz_zero[5] = (w_act_data_nxt[23:20] == 4'h0);
        for (int i = 4; i >= 0; i--) begin
            w_lz_zero[i] = w_lz_zero[i+1] && (w_act_data_nxt[4*i +: 4] == 4'h0);
        end
        w_blank = w_lz_zero & {6{w_act_lz_nxt}} & 6'b111110;
    end

    always_comb begin
        w_dig       = w_act_data_nxt[3:0];
        w_dig_dot   = w_act_dot_nxt[0];
        w_dig_blank = w_blank[0];
        case (w_idx_nxt)
            3'd1: begin w_dig = w_act_data_nxt[7:4];   w_dig_dot = w_act_dot_nxt[1]; w_dig_blank = w_blank[1]; end
            3'd2: begin w_dig = w_act_data_nxt[11:8];  w_dig_dot = w_act_dot_nxt[2]; w_dig_blank = w_blank[2]; end
            3'd3: begin w_dig = w_act_data_nxt[15:12]; w_dig_dot = w_act_dot_nxt[3]; w_dig_blank = w_blank[3]; end
            3'd4: begin w_dig = w_act_data_nxt[19:16]; w_dig_dot = w_act_dot_nxt[4]; w_dig_blank = w_blank[4]; end
            3'd5: begin w_dig = w_act_data_nxt[23:20]; w_dig_dot = w_act_dot_nxt[5]; w_dig_blank = w_blank[5]; end
            default: ;
        endcase
    end

    always_comb begin
        w_seg_nxt = 8'hFF;
        if (w_cnt_nxt >= C_BLANK) begin
            w_seg_nxt = {~w_dig_dot, (w_dig_blank ? 7'h7F : f_hex7(w_dig))};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt         <= '0;
            r_idx         <= 3'd0;
            r_act_data    <= 24'h0;
            r_act_dot     <= 6'h0;
            r_act_lz      <= 1'b0;
            r_pnd_data    <= 24'h0;
            r_pnd_dot     <= 6'h0;
            r_pnd_lz      <= 1'b0;
            r_pending     <= 1'b0;
            r_frame_start <= 1'b0;
            r_sel         <= 6'b000001;
            r_seg         <= 8'hFF;
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_act_data    <= w_act_data_nxt;
            r_act_dot     <= w_act_dot_nxt;
            r_act_lz      <= w_act_lz_nxt;
            r_frame_start <= w_boundary;
            r_sel         <= 6'b000001 << w_idx_nxt;
            r_seg         <= w_seg_nxt;
            // A load on the boundary bypasses the pending buffer entirely.
            if (load && !w_boundary) begin
                r_pnd_data <= data_in;
                r_pnd_dot  <= dot_in;
                r_pnd_lz   <= lz_en;
                r_pending  <= 1'b1;
            end else if (w_boundary) begin
                r_pending  <= 1'b0;
            end
        end
    end

    assign pending     = r_pending;
    assign frame_start = r_frame_start;
    assign sel         = r_sel;
    assign seg         = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg_dyn_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_dyn_scan
//  Purpose  : Directed self-checking bench for seg_dyn_scan with CNT_MAX=9,
//             BLANK_CYC=2 (10-clock slots, 60-clock frames).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_dyn_scan;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        load;
    logic [23:0] data_in;
    logic [5:0]  dot_in;
    logic        lz_en;
    logic        pending;
    logic        frame_start;
    logic [5:0]  sel;
    logic [7:0]  seg;

    int          n_checks;
    int          n_errors;
    int          k;              // clock edges since reset release
    logic [7:0]  exp_pat [6];    // expected post-guard pattern per digit

    seg_dyn_scan #(
        .CNT_MAX   (9),
        .BLANK_CYC (2)
    ) u_dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .load        (load),
        .data_in     (data_in),
        .dot_in      (dot_in),
        .lz_en       (lz_en),
        .pending     (pending),
        .frame_start (frame_start),
        .sel         (sel),
        .seg         (seg)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s k=%0d got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    // Advance n clocks; after each, check all outputs against the slot position.
    task automatic adv_n(input int n, input logic pend);
        int cnt;
        int idx;
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            k++;
            cnt = k % 10;
            idx = (k / 10) % 6;
            chk("sel", 32'(sel), 32'd1 << idx);
            chk("seg", 32'(seg), (cnt < 2) ? 32'hFF : 32'(exp_pat[idx]));
            chk("frame_start", 32'(frame_start), (k % 60 == 0) ? 32'd1 : 32'd0);
            chk("pending", 32'(pending), 32'(pend));
        end
    endtask

    task automatic set_pat(input logic [7:0] p5, input logic [7:0] p4, input logic [7:0] p3,
                           input logic [7:0] p2, input logic [7:0] p1, input logic [7:0] p0);
        exp_pat[5] = p5; exp_pat[4] = p4; exp_pat[3] = p3;
        exp_pat[2] = p2; exp_pat[1] = p1; exp_pat[0] = p0;
    endtask

    task automatic do_load(input logic [23:0] d, input logic [5:0] dp, input logic lz);
        load    = 1'b1;
        data_in = d;
        dot_in  = dp;
        lz_en   = lz;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sel"}, 32'(sel), 32'h01);
        chk({tag, "_seg"}, 32'(seg), 32'hFF);
        chk({tag, "_pending"}, 32'(pending), 32'd0);
        chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        k         = 0;
        sys_rst_n = 1'b0;
        load      = 1'b0;
        data_in   = 24'h0;
        dot_in    = 6'h0;
        lz_en     = 1'b0;
        set_pat(8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0);

        // 1. Reset, then one full frame of zeros.
        repeat (3) @(negedge sys_clk);
        chk_reset_vals("rst");
        sys_rst_n = 1'b1;
        k = 0;
        adv_n(60, 1'b0);

        // 2. Load mid-frame at idx=2; rest of frame still shows zeros.
        adv_n(25, 1'b0);                                 // k=85: idx 2, cnt 5
        do_load(24'h12345F, 6'b000010, 1'b0);
        adv_n(1, 1'b1);
        load = 1'b0;
        adv_n(33, 1'b1);                                 // k=119: boundary
        set_pat(8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h12, 8'h8E);
        adv_n(1, 1'b0);                                  // k=120

        // 3. Leading-zero blanking content, loaded mid-frame.
        adv_n(30, 1'b0);                                 // k=150
        do_load(24'h000070, 6'b000100, 1'b1);
        adv_n(1, 1'b1);
        load = 1'b0;
        adv_n(28, 1'b1);                                 // k=179
        set_pat(8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'hF8, 8'hC0);
        adv_n(1, 1'b0);                                  // k=180

        // 4. Two loads in one frame: only the second survives.
        adv_n(15, 1'b0);                                 // k=195
        do_load(24'h111111, 6'b000000, 1'b0);
        adv_n(1, 1'b1);
        load = 1'b0;
        adv_n(10, 1'b1);                                 // k=206
        do_load(24'h222222, 6'b000000, 1'b0);
        adv_n(1, 1'b1);
        load = 1'b0;
        adv_n(32, 1'b1);                                 // k=239
        set_pat(8'hA4, 8'hA4, 8'hA4, 8'hA4, 8'hA4, 8'hA4);
        adv_n(1, 1'b0);                                  // k=240

        // 5. Load exactly on the boundary cycle goes straight to active.
        adv_n(59, 1'b0);                                 // k=299
        do_load(24'h456789, 6'b000000, 1'b0);
        set_pat(8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90);
        adv_n(1, 1'b0);                                  // k=300
        load = 1'b0;

        // 6. Async reset at idx=3, cnt=5 with content pending.
        adv_n(30, 1'b0);                                 // k=330
        do_load(24'hFFFFFF, 6'b111111, 1'b0);
        adv_n(1, 1'b1);
        load = 1'b0;
        adv_n(4, 1'b1);                                  // k=335: idx 3, cnt 5
        #2 sys_rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        repeat (2) @(negedge sys_clk);
        chk_reset_vals("hold_rst");
        sys_rst_n = 1'b1;
        k = 0;
        set_pat(8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        adv_n(60, 1'b0);                                 // pending data discarded

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
